// File: rtl/sync_fifo_ctl_gen2.sv
// Parametrised single-clock FIFO controller with its own storage, optional
// first-word-fall-through read, occupancy count and sticky overrun/underrun flags.
module sync_fifo_ctl_gen2 #(
    parameter int DATA_WIDTH = 18,
    parameter int ADDR_WIDTH = 10,
    parameter int FWFT       = 0
) (
    input  logic                  CLK_i,
    input  logic                  RESET_ni,
    input  logic                  FLUSH_ni,
    input  logic                  WEN_i,
    input  logic [DATA_WIDTH-1:0] WDATA_i,
    input  logic                  REN_i,
    output logic [DATA_WIDTH-1:0] RDATA_o,
    input  logic [ADDR_WIDTH:0]   UPAE_i,
    input  logic [ADDR_WIDTH:0]   UPAF_i,
    output logic [ADDR_WIDTH:0]   COUNT_o,
    output logic                  EMPTY_o,
    output logic                  EPO_o,
    output logic                  EWM_o,
    output logic                  FULL_o,
    output logic                  FMO_o,
    output logic                  FWM_o,
    output logic                  OVERRUN_o,
    output logic                  UNDERRUN_o
);

    localparam int                DEPTH      = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_C  = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] DEPTH_M1 = {1'b0, {ADDR_WIDTH{1'b1}}};
    localparam logic [ADDR_WIDTH:0] PTR_ONE  = 1;
    localparam logic [ADDR_WIDTH:0] PTR_ZERO = '0;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [ADDR_WIDTH:0] wptr_reg, rptr_reg, count_reg;
    logic [ADDR_WIDTH:0] wptr_next, rptr_next;
    logic                overrun_reg, underrun_reg;
    logic                wr_acc, rd_acc, active;
    logic [ADDR_WIDTH:0] fwm_thr;

    // Reset and flush both squash the cycle's operations, memory included.
    assign active = RESET_ni & FLUSH_ni;
    assign wr_acc = WEN_i & ~FULL_o;
    assign rd_acc = REN_i & ~EMPTY_o;

    assign wptr_next = wr_acc ? wptr_reg + PTR_ONE : wptr_reg;
    assign rptr_next = rd_acc ? rptr_reg + PTR_ONE : rptr_reg;

    always_ff @(posedge CLK_i) begin
        if (active && wr_acc) begin
            mem[wptr_reg[ADDR_WIDTH-1:0]] <= WDATA_i;
        end
    end

    always_ff @(posedge CLK_i) begin
        if (!RESET_ni || !FLUSH_ni) begin
            wptr_reg     <= '0;
            rptr_reg     <= '0;
            count_reg    <= '0;
            overrun_reg  <= 1'b0;
            underrun_reg <= 1'b0;
        end else begin
            wptr_reg  <= wptr_next;
            rptr_reg  <= rptr_next;
            count_reg <= wptr_next - rptr_next;
            if (WEN_i && FULL_o) begin
                overrun_reg <= 1'b1;
            end
            if (REN_i && EMPTY_o) begin
                underrun_reg <= 1'b1;
            end
        end
    end

    generate
        if (FWFT == 0) begin : g_reg_read
            logic [DATA_WIDTH-1:0] rdata_reg;
            always_ff @(posedge CLK_i) begin
                if (!RESET_ni || !FLUSH_ni) begin
                    rdata_reg <= '0;
                end else if (rd_acc) begin
                    rdata_reg <= mem[rptr_reg[ADDR_WIDTH-1:0]];
                end
            end
            assign RDATA_o = rdata_reg;
        end else begin : g_fwft_read
            // Head word is presented directly; zero while nothing is stored.
            assign RDATA_o = EMPTY_o ? '0 : mem[rptr_reg[ADDR_WIDTH-1:0]];
        end
    endgenerate

    // Thresholds above the depth saturate the watermark to always-on.
    assign fwm_thr = (UPAF_i > DEPTH_C) ? PTR_ZERO : DEPTH_C - UPAF_i;

    assign COUNT_o    = count_reg;
    assign EMPTY_o    = (count_reg == PTR_ZERO);
    assign EPO_o      = (count_reg == PTR_ONE);
    assign EWM_o      = (UPAE_i >= DEPTH_C) | (count_reg <= UPAE_i);
    assign FULL_o     = (count_reg == DEPTH_C);
    assign FMO_o      = (count_reg == DEPTH_M1);
    assign FWM_o      = (count_reg >= fwm_thr);
    assign OVERRUN_o  = overrun_reg;
    assign UNDERRUN_o = underrun_reg;

endmodule

// File: tb/tb_sync_fifo_ctl_gen2.sv
// Directed bench for sync_fifo_ctl_gen2: a registered-read and an FWFT instance
// share one stimulus stream, depth 16, 8-bit data.
module tb_sync_fifo_ctl_gen2;

    localparam int DW = 8;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          reset_n, flush_n, wen, ren;
    logic [DW-1:0] wdata;
    logic [AW:0]   upae, upaf;

    logic [DW-1:0] rdata0, rdata1;
    logic [AW:0]   count0, count1;
    logic empty0, epo0, ewm0, full0, fmo0, fwm0, ovr0, und0;
    logic empty1, epo1, ewm1, full1, fmo1, fwm1, ovr1, und1;

    int checks = 0;
    int errors = 0;
    int txn    = 0;

    always #5 clk = ~clk;

    sync_fifo_ctl_gen2 #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FWFT(0)) u_dut0 (
        .CLK_i(clk), .RESET_ni(reset_n), .FLUSH_ni(flush_n),
        .WEN_i(wen), .WDATA_i(wdata), .REN_i(ren), .RDATA_o(rdata0),
        .UPAE_i(upae), .UPAF_i(upaf), .COUNT_o(count0),
        .EMPTY_o(empty0), .EPO_o(epo0), .EWM_o(ewm0),
        .FULL_o(full0), .FMO_o(fmo0), .FWM_o(fwm0),
        .OVERRUN_o(ovr0), .UNDERRUN_o(und0)
    );

    sync_fifo_ctl_gen2 #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FWFT(1)) u_dut1 (
        .CLK_i(clk), .RESET_ni(reset_n), .FLUSH_ni(flush_n),
        .WEN_i(wen), .WDATA_i(wdata), .REN_i(ren), .RDATA_o(rdata1),
        .UPAE_i(upae), .UPAF_i(upaf), .COUNT_o(count1),
        .EMPTY_o(empty1), .EPO_o(epo1), .EWM_o(ewm1),
        .FULL_o(full1), .FMO_o(fmo1), .FWM_o(fwm1),
        .OVERRUN_o(ovr1), .UNDERRUN_o(und1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock with the given request; outputs are sampled 1 ns after the edge.
    task automatic step(input logic w, input logic [DW-1:0] d, input logic r);
        wen   = w;
        wdata = d;
        ren   = r;
        @(posedge clk);
        #1;
        wen = 1'b0;
        ren = 1'b0;
        txn++;
        $display("txn %0d: rst_n=%0b flush_n=%0b wen=%0b wdata=%02h ren=%0b -> count=%0d rdata0=%02h rdata1=%02h",
                 txn, reset_n, flush_n, w, d, r, count0, rdata0, rdata1);
    endtask

    initial begin
        reset_n = 1'b0;
        flush_n = 1'b1;
        wen     = 1'b0;
        ren     = 1'b0;
        wdata   = '0;
        upae    = 5'd3;
        upaf    = 5'd2;
        repeat (2) @(posedge clk);
        #1;

        chk("rst_count",  32'(count0), 32'd0);
        chk("rst_empty",  32'(empty0), 32'd1);
        chk("rst_ewm",    32'(ewm0),   32'd1);
        chk("rst_epo",    32'(epo0),   32'd0);
        chk("rst_full",   32'(full0),  32'd0);
        chk("rst_fmo",    32'(fmo0),   32'd0);
        chk("rst_fwm",    32'(fwm0),   32'd0);
        chk("rst_ovr",    32'(ovr0),   32'd0);
        chk("rst_und",    32'(und0),   32'd0);
        chk("rst_rdata0", 32'(rdata0), 32'd0);
        chk("rst_rdata1", 32'(rdata1), 32'd0);
        upaf = 5'd16;
        #1;
        chk("rst_fwm_upaf16", 32'(fwm0), 32'd1);
        upaf = 5'd20;
        #1;
        chk("fwm_clamp", 32'(fwm0), 32'd1);
        upaf = 5'd2;
        reset_n = 1'b1;

        // Fill to full, checking every flag along the way
        for (int i = 1; i <= 16; i++) begin
            step(1'b1, 8'(i), 1'b0);
            chk("fill_count",  32'(count0), 32'(i));
            chk("fill_count1", 32'(count1), 32'(i));
            chk("fill_epo",    32'(epo0),   32'(i == 1));
            chk("fill_fmo",    32'(fmo0),   32'(i == 15));
            chk("fill_full",   32'(full0),  32'(i == 16));
            chk("fill_ewm",    32'(ewm0),   32'(i <= 3));
            chk("fill_fwm",    32'(fwm0),   32'(i >= 14));
            chk("fill_rdata1", 32'(rdata1), 32'd1);
        end
        upae = 5'd16;
        #1;
        chk("ewm_force", 32'(ewm0), 32'd1);
        upae = 5'd3;

        step(1'b1, 8'h99, 1'b0);
        chk("ovr_count",  32'(count0), 32'd16);
        chk("ovr_flag",   32'(ovr0),   32'd1);
        chk("ovr_flag1",  32'(ovr1),   32'd1);
        chk("ovr_rdata0", 32'(rdata0), 32'd0);

        // Full with both requests: read wins, write dropped
        step(1'b1, 8'h77, 1'b1);
        chk("fullrw_rdata0", 32'(rdata0), 32'd1);
        chk("fullrw_rdata1", 32'(rdata1), 32'd2);
        chk("fullrw_count",  32'(count0), 32'd15);
        chk("fullrw_ovr",    32'(ovr0),   32'd1);

        for (int k = 2; k <= 16; k++) begin
            step(1'b0, 8'h00, 1'b1);
            chk("drain_rdata0", 32'(rdata0), 32'(k));
            chk("drain_rdata1", 32'(rdata1), (k < 16) ? 32'(k + 1) : 32'd0);
            chk("drain_count",  32'(count0), 32'(16 - k));
        end
        chk("drain_empty", 32'(empty0), 32'd1);

        // Empty with both requests: write wins, read rejected
        step(1'b1, 8'h55, 1'b1);
        chk("emptyrw_count",  32'(count0), 32'd1);
        chk("emptyrw_und",    32'(und0),   32'd1);
        chk("emptyrw_rdata0", 32'(rdata0), 32'd16);
        chk("emptyrw_rdata1", 32'(rdata1), 32'h55);

        // Flush with a write pending
        flush_n = 1'b0;
        step(1'b1, 8'h66, 1'b0);
        flush_n = 1'b1;
        chk("flush_count",  32'(count0), 32'd0);
        chk("flush_empty",  32'(empty0), 32'd1);
        chk("flush_ovr",    32'(ovr0),   32'd0);
        chk("flush_und",    32'(und0),   32'd0);
        chk("flush_rdata0", 32'(rdata0), 32'd0);
        chk("flush_rdata1", 32'(rdata1), 32'd0);

        // Registered-read latency and underrun hold
        step(1'b1, 8'hA5, 1'b0);
        chk("a5_count",   32'(count0), 32'd1);
        chk("a5_rdata0",  32'(rdata0), 32'd0);
        chk("a5_rdata1",  32'(rdata1), 32'hA5);
        step(1'b0, 8'h00, 1'b1);
        chk("a5_rd_rdata0", 32'(rdata0), 32'hA5);
        chk("a5_rd_rdata1", 32'(rdata1), 32'd0);
        chk("a5_rd_empty",  32'(empty0), 32'd1);
        step(1'b0, 8'h00, 1'b1);
        chk("a5_und",        32'(und0),   32'd1);
        chk("a5_und_rdata0", 32'(rdata0), 32'hA5);

        flush_n = 1'b0;
        step(1'b0, 8'h00, 1'b0);
        flush_n = 1'b1;
        chk("flush2_und", 32'(und0), 32'd0);

        // FWFT fall-through without a read request
        step(1'b1, 8'h3C, 1'b0);
        chk("3c_rdata1", 32'(rdata1), 32'h3C);
        chk("3c_empty1", 32'(empty1), 32'd0);
        step(1'b0, 8'h00, 1'b1);
        chk("3c_rd_empty1", 32'(empty1), 32'd1);
        chk("3c_rd_rdata1", 32'(rdata1), 32'd0);
        chk("3c_rd_rdata0", 32'(rdata0), 32'h3C);

        // Stream 40 words with one in flight, wrapping the pointers twice
        step(1'b1, 8'h80, 1'b0);
        for (int i = 1; i < 40; i++) begin
            step(1'b1, 8'(8'h80 + i), 1'b1);
            chk("stream_rdata0", 32'(rdata0), 32'(8'h80 + i - 1));
            chk("stream_rdata1", 32'(rdata1), 32'(8'h80 + i));
            chk("stream_count",  32'(count0), 32'd1);
        end
        step(1'b0, 8'h00, 1'b1);
        chk("stream_last", 32'(rdata0), 32'(8'h80 + 39));
        chk("stream_empty", 32'(empty0), 32'd1);

        // Reset mid-stream with a write pending
        step(1'b0, 8'h00, 1'b1);
        chk("pre_rst_und", 32'(und0), 32'd1);
        step(1'b1, 8'h11, 1'b0);
        step(1'b1, 8'h22, 1'b0);
        chk("pre_rst_count", 32'(count0), 32'd2);
        reset_n = 1'b0;
        step(1'b1, 8'h33, 1'b0);
        reset_n = 1'b1;
        chk("rst2_count",  32'(count0), 32'd0);
        chk("rst2_empty",  32'(empty0), 32'd1);
        chk("rst2_und",    32'(und0),   32'd0);
        chk("rst2_ovr",    32'(ovr0),   32'd0);
        chk("rst2_rdata0", 32'(rdata0), 32'd0);
        chk("rst2_rdata1", 32'(rdata1), 32'd0);
        step(1'b1, 8'h44, 1'b0);
        chk("post_rst_rdata1", 32'(rdata1), 32'h44);
        chk("post_rst_count",  32'(count1), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
